muldiv_issue: RTL and testbench
===============================

# muldiv_issue

Requester-side controller for the iterative `muldiv` unit. It sits in the execute stage between the integer pipeline and `muldiv`. It accepts one M-extension request at a time through a valid/ready handshake, drives `muldiv`'s start/ack protocol, and buffers the result until writeback accepts it. It also handles pipeline flushes: an in-flight operation is drained and its result discarded. A watchdog flags a `muldiv` that never completes.

## Interface
- `OP_LN`, default 32: operand and result width.
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before `err_timeout` is set.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_op1`, `req_op2` in OP_LN: rs1 and rs2 values.
- `req_funct3` in 3: M-extension funct3.
- `req_rd` in 5: destination register tag.
- `flush` in 1: kill any in-flight or buffered request.
- `md_op1`, `md_op2` out OP_LN: operands to `muldiv`, held stable from START until ack.
- `md_funct3` out 3: operation to `muldiv`.
- `md_start` out 1: single-cycle start pulse.
- `md_ack` out 1: single-cycle acknowledge.
- `md_result` in OP_LN: `muldiv` result, valid while `md_done` is high.
- `md_done` in 1: `muldiv` completion; stays high until acked.
- `wb_valid` out 1: result available to writeback.
- `wb_ready` in 1: writeback accepts.
- `wb_data` out OP_LN: result.
- `wb_rd` out 5: destination tag.
- `busy` out 1: state is not IDLE.
- `err_timeout` out 1: sticky watchdog flag; cleared only by reset.

## Operation
- **States:** IDLE, START, WAIT, RESP, DRAIN.
- **`req_ready`:** `(IDLE | (RESP & wb_ready)) & ~flush`.
- **IDLE:** on accept, register op1, op2, funct3 and rd, then go to START.
- **START:** `md_start=1` for exactly one cycle, then go to WAIT. With `flush`, go to DRAIN instead (the start is still issued).
- **WAIT:**
  - On `md_done`: `md_ack=1` in the same cycle, capture `md_result` into `wb_data`, go to RESP.
  - With `flush` and no `md_done`: go to DRAIN.
  - With `flush` and `md_done` together: ack and discard, go to IDLE.
- **RESP:**
  - `wb_valid=1`.
  - On `wb_ready`: go to IDLE. If a new request is accepted in the same cycle, go straight to START.
  - With `flush`: drop `wb_valid` and go to IDLE; no accept that cycle.
- **DRAIN:** wait for `md_done`, pulse `md_ack`, discard the result, go to IDLE. `flush` in DRAIN has no effect.
- **`md_ack`:** combinational, `(WAIT | DRAIN) & md_done`.
- **Operands:** `md_op1`, `md_op2` and `md_funct3` come from the request registers and change only on accept.
- **Arithmetic:** none. Results pass through unmodified. Div-by-zero and overflow semantics belong to `muldiv`.
- **Watchdog:** a counter of `$clog2(TIMEOUT+1)` bits. It clears on entry to WAIT or DRAIN, increments in those states, and saturates. On reaching `TIMEOUT` it sets `err_timeout`. The FSM keeps waiting regardless.

## Timing
- **Reset values:** state=IDLE. `md_start`, `md_ack`, `wb_valid`, `busy`, `err_timeout` = 0. Data and tag registers = 0. `req_ready` = 1.
- **Reset mid-operation:** abandons the operation. `muldiv` shares `rst_n`.
- **Latency:** accept at cycle 0, `md_start` at cycle 1. If `muldiv` raises `md_done` at cycle 1+N, then `md_ack` is at cycle 1+N and `wb_valid` at cycle 2+N.
- **Back-to-back:** a new accept coincides with the previous `wb_valid & wb_ready` cycle. The next `md_start` is one cycle later, never in the same cycle as an ack.
- **Backpressure:** while `wb_ready=0`, `wb_valid`, `wb_data` and `wb_rd` hold stable.
- **`md_start`:** never asserted while an operation is outstanding in `muldiv`.

## Structure
- **Shared package `muldiv_pkg`:**
  - funct3 enum: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - Issue-state enum.
  - Default `OP_LN`.
- **Sub-modules:** none required. The watchdog is an inline counter. `muldiv` is instantiated by the parent, not inside this block.

## Test plan
- **MUL:** op1=7, op2=6, funct3=000 against a behavioural `muldiv` with N=4. Expect one `md_start`, `md_ack` with `md_done`, then `wb_valid` with `wb_data`=42 and `wb_rd` = the request tag, 6 cycles after accept.
- **DIVU with backpressure:** op1=100, op2=7, funct3=101, `wb_ready` held low for 5 cycles. Expect `wb_data`=14 held stable with `wb_valid` high throughout, and `req_ready`=0 until the handshake.
- **Flush in WAIT:** assert `flush` 2 cycles after `md_start`. Expect a single `md_ack` when `md_done` rises, no `wb_valid`, and the next request (REM, 100, 7) returning 2.
- **Back-to-back:** MULHU 0xFFFFFFFF×2 then MUL 3×3, with `req_valid` held and `wb_ready`=1. Expect results 0x00000001 then 9, and exactly one `md_start` per request.
- **Flush coincident with `md_done` in WAIT:** expect ack, discard, IDLE next cycle, and `req_ready`=1.
- **Watchdog:** the model withholds `md_done` and `TIMEOUT`=8. Expect `err_timeout` high after 8 WAIT cycles and remaining high. A late `md_done` still produces ack and `wb_valid`.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the M-extension multiply/divide path: the funct3
// operation encoding, the issue-controller state encoding, the default
// operand width and a small state-classification helper.
// Ports: none (package).
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int DEFAULT_OP_LN   = 32;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } issue_state_e;

    // States in which an operation is outstanding inside muldiv and the
    // watchdog is counting.
    function automatic logic is_watched(input issue_state_e s);
        return (s == ST_WAIT) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/muldiv_issue_if.sv
// -----------------------------------------------------------------------------
// muldiv_issue_if
// Bundles the three handshakes around the muldiv issue controller:
//   req_*  : pipeline -> controller request (valid/ready)
//   md_*   : controller <-> muldiv start/done/ack protocol
//   wb_*   : controller -> writeback result (valid/ready)
// Modports:
//   master : the issue controller's view (drives req_ready, md_*, wb_* outputs)
//   slave  : the surrounding pipeline / muldiv / writeback view
// -----------------------------------------------------------------------------
interface muldiv_issue_if
    import muldiv_pkg::*;
#(
    parameter int OP_LN = DEFAULT_OP_LN
) ();

    logic             req_valid;
    logic             req_ready;
    logic [OP_LN-1:0] req_op1;
    logic [OP_LN-1:0] req_op2;
    logic [2:0]       req_funct3;
    logic [4:0]       req_rd;

    logic [OP_LN-1:0] md_op1;
    logic [OP_LN-1:0] md_op2;
    logic [2:0]       md_funct3;
    logic             md_start;
    logic             md_ack;
    logic [OP_LN-1:0] md_result;
    logic             md_done;

    logic             wb_valid;
    logic             wb_ready;
    logic [OP_LN-1:0] wb_data;
    logic [4:0]       wb_rd;

    modport master (
        input  req_valid, req_op1, req_op2, req_funct3, req_rd,
        output req_ready,
        output md_op1, md_op2, md_funct3, md_start, md_ack,
        input  md_result, md_done,
        output wb_valid, wb_data, wb_rd,
        input  wb_ready
    );

    modport slave (
        output req_valid, req_op1, req_op2, req_funct3, req_rd,
        input  req_ready,
        input  md_op1, md_op2, md_funct3, md_start, md_ack,
        output md_result, md_done,
        input  wb_valid, wb_data, wb_rd,
        output wb_ready
    );

endinterface

// File: rtl/muldiv_issue.sv
// -----------------------------------------------------------------------------
// muldiv_issue
// Execute-stage requester for the iterative muldiv unit. Accepts one request
// at a time, issues it to muldiv with a single-cycle start pulse, acks the
// completion, and holds the result for writeback. Flushes drain any operation
// already started in muldiv and discard its result. A saturating watchdog
// raises a sticky flag if muldiv stays silent for TIMEOUT cycles.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   flush         : kill any in-flight or buffered request
//   busy          : controller is not idle
//   err_timeout   : sticky watchdog flag, cleared only by reset
//   bus (master)  : req_* / md_* / wb_* handshakes
// -----------------------------------------------------------------------------
module muldiv_issue
    import muldiv_pkg::*;
#(
    parameter int OP_LN   = DEFAULT_OP_LN,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    output logic           busy,
    output logic           err_timeout,
    muldiv_issue_if.master bus
);

    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    issue_state_e     state_q, state_d;
    logic [OP_LN-1:0] op1_q, op1_d;
    logic [OP_LN-1:0] op2_q, op2_d;
    funct3_e          funct3_q, funct3_d;
    logic [4:0]       rd_q, rd_d;
    logic [OP_LN-1:0] wbData_q, wbData_d;
    logic [WD_W-1:0]  wdCnt_q, wdCnt_d;
    logic             errTimeout_q, errTimeout_d;

    logic reqReady;
    logic accept;

    always_comb begin
        state_d      = state_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        wbData_d     = wbData_q;
        wdCnt_d      = wdCnt_q;
        errTimeout_d = errTimeout_q;

        // A new request may slip in during the cycle the buffered result
        // leaves, which is what makes back-to-back issue possible.
        reqReady = ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.wb_ready)) && !flush;
        accept   = bus.req_valid && reqReady;

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_START;
            end
            ST_START: begin
                // The start pulse goes out regardless, so a flush here must
                // still wait for muldiv to finish.
                state_d = flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.md_done) state_d = flush ? ST_IDLE : ST_RESP;
                else if (flush)  state_d = ST_DRAIN;
            end
            ST_RESP: begin
                if (flush)            state_d = ST_IDLE;
                else if (bus.wb_ready) state_d = accept ? ST_START : ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.md_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            op1_d    = bus.req_op1;
            op2_d    = bus.req_op2;
            funct3_d = funct3_e'(bus.req_funct3);
            rd_d     = bus.req_rd;
        end

        if ((state_q == ST_WAIT) && bus.md_done && !flush) wbData_d = bus.md_result;

        // Restart on entry to a waiting state; count only while staying put.
        if (is_watched(state_d) && (state_d != state_q)) begin
            wdCnt_d = '0;
        end else if (is_watched(state_q) && (state_d == state_q) && (wdCnt_q != WD_MAX)) begin
            wdCnt_d = wdCnt_q + WD_W'(1);
        end
        errTimeout_d = errTimeout_q || (wdCnt_d == WD_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op1_q        <= '0;
            op2_q        <= '0;
            funct3_q     <= MUL;
            rd_q         <= '0;
            wbData_q     <= '0;
            wdCnt_q      <= '0;
            errTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            wbData_q     <= wbData_d;
            wdCnt_q      <= wdCnt_d;
            errTimeout_q <= errTimeout_d;
        end
    end

    assign bus.req_ready = reqReady;
    assign bus.md_op1    = op1_q;
    assign bus.md_op2    = op2_q;
    assign bus.md_funct3 = funct3_q;
    assign bus.md_start  = (state_q == ST_START);
    assign bus.md_ack    = is_watched(state_q) && bus.md_done;
    // A flushed result must not be seen by writeback even in its last cycle.
    assign bus.wb_valid  = (state_q == ST_RESP) && !flush;
    assign bus.wb_data   = wbData_q;
    assign bus.wb_rd     = rd_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_timeout   = errTimeout_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// -----------------------------------------------------------------------------
// tb_muldiv_issue
// Self-checking bench for muldiv_issue with a behavioural muldiv model that
// computes results with plain 64-bit arithmetic and answers after a
// programmable number of cycles (or never, until released).
// -----------------------------------------------------------------------------
module tb_muldiv_issue;
    import muldiv_pkg::*;

    localparam int OP_LN   = 32;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic busy;
    logic errTimeout;

    muldiv_issue_if #(.OP_LN(OP_LN)) bus ();

    muldiv_issue #(.OP_LN(OP_LN), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .busy        (busy),
        .err_timeout (errTimeout),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;
    int startCount = 0;
    int ackCount = 0;
    bit startOverlap = 1'b0;
    bit startAckSame = 1'b0;
    int mdLatency = 1;
    bit mdHold = 1'b0;
    bit mdBusy;
    int mdRemain;

    // Architectural result of an M-extension op, straight from the ISA rules.
    function automatic logic [31:0] refCompute(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] f);
        longint sa, sb, sq;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        refCompute = 32'd0;
        case (f)
            MUL:    begin p = ua * ub; refCompute = p[31:0]; end
            MULH:   begin p = sa * sb; refCompute = p[63:32]; end
            MULHSU: begin p = sa * longint'(ub); refCompute = p[63:32]; end
            MULHU:  begin p = ua * ub; refCompute = p[63:32]; end
            DIV:    if (b == 32'd0) refCompute = 32'hFFFF_FFFF;
                    else begin sq = sa / sb; refCompute = sq[31:0]; end
            DIVU:   if (b == 32'd0) refCompute = 32'hFFFF_FFFF;
                    else begin p = ua / ub; refCompute = p[31:0]; end
            REM:    if (b == 32'd0) refCompute = a;
                    else begin sq = sa % sb; refCompute = sq[31:0]; end
            default: if (b == 32'd0) refCompute = a;
                    else begin p = ua % ub; refCompute = p[31:0]; end
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Behavioural muldiv: latches operands at start, raises done mdLatency
    // cycles later and keeps it high until acked.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.md_done   <= 1'b0;
            bus.md_result <= '0;
            mdBusy        <= 1'b0;
            mdRemain      <= 0;
        end else begin
            if (bus.md_ack) begin
                bus.md_done <= 1'b0;
                mdBusy      <= 1'b0;
            end
            if (bus.md_start) begin
                if (mdBusy) startOverlap <= 1'b1;
                mdBusy        <= 1'b1;
                bus.md_result <= refCompute(bus.md_op1, bus.md_op2, bus.md_funct3);
                mdRemain      <= mdLatency - 1;
                if (mdLatency <= 1 && !mdHold) bus.md_done <= 1'b1;
            end else if (mdBusy && !bus.md_done) begin
                if (mdRemain <= 1 && !mdHold) bus.md_done <= 1'b1;
                if (mdRemain > 0) mdRemain <= mdRemain - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.md_start) startCount <= startCount + 1;
            if (bus.md_ack) ackCount <= ackCount + 1;
            if (bus.md_start && bus.md_ack) startAckSame <= 1'b1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "[TB] simulation stopped");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a request and returns one cycle after it was accepted
    // (the START cycle).
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f, input logic [4:0] rd);
        int budget;
        bus.req_op1    = a;
        bus.req_op2    = b;
        bus.req_funct3 = f;
        bus.req_rd     = rd;
        bus.req_valid  = 1'b1;
        #1;
        budget = 0;
        while (!bus.req_ready && budget < 50) begin
            tick();
            budget++;
        end
        checkOutput("accept ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (!bus.wb_valid && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    task automatic runTxn(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input logic [4:0] rd, input int n, input int bp);
        logic [31:0] exp;
        int cyc, s0, a0;
        exp = refCompute(a, b, f);
        mdLatency = n;
        bus.wb_ready = (bp == 0);
        s0 = startCount;
        a0 = ackCount;
        applyStimulus(a, b, f, rd);
        checkOutput({tag, " md_start"}, 64'(bus.md_start), 64'd1);
        checkOutput({tag, " md_op1"}, 64'(bus.md_op1), 64'(a));
        checkOutput({tag, " md_op2"}, 64'(bus.md_op2), 64'(b));
        waitValid(cyc);
        checkOutput({tag, " wb_valid"}, 64'(bus.wb_valid), 64'd1);
        checkOutput({tag, " latency"}, 64'(cyc), 64'(n + 1));
        checkOutput({tag, " wb_data"}, 64'(bus.wb_data), 64'(exp));
        checkOutput({tag, " wb_rd"}, 64'(bus.wb_rd), 64'(rd));
        for (int k = 0; k < bp; k++) begin
            tick();
            checkOutput({tag, " bp wb_valid"}, 64'(bus.wb_valid), 64'd1);
            checkOutput({tag, " bp wb_data"}, 64'(bus.wb_data), 64'(exp));
            checkOutput({tag, " bp wb_rd"}, 64'(bus.wb_rd), 64'(rd));
            checkOutput({tag, " bp req_ready"}, 64'(bus.req_ready), 64'd0);
        end
        bus.wb_ready = 1'b1;
        #1;
        checkOutput({tag, " handshake req_ready"}, 64'(bus.req_ready), 64'd1);
        tick();
        checkOutput({tag, " wb_valid cleared"}, 64'(bus.wb_valid), 64'd0);
        checkOutput({tag, " busy cleared"}, 64'(busy), 64'd0);
        checkOutput({tag, " start count"}, 64'(startCount - s0), 64'd1);
        checkOutput({tag, " ack count"}, 64'(ackCount - a0), 64'd1);
    endtask

    initial begin
        int cyc, s0, a0;
        bit sawValid;
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op1    = '0;
        bus.req_op2    = '0;
        bus.req_funct3 = '0;
        bus.req_rd     = '0;
        bus.wb_ready   = 1'b1;
        repeat (3) tick();

        // Reset state
        checkOutput("reset req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset md_start", 64'(bus.md_start), 64'd0);
        checkOutput("reset md_ack", 64'(bus.md_ack), 64'd0);
        checkOutput("reset wb_valid", 64'(bus.wb_valid), 64'd0);
        checkOutput("reset err_timeout", 64'(errTimeout), 64'd0);
        checkOutput("reset wb_data", 64'(bus.wb_data), 64'd0);
        checkOutput("reset wb_rd", 64'(bus.wb_rd), 64'd0);
        checkOutput("reset md_op1", 64'(bus.md_op1), 64'd0);
        rst_n = 1'b1;
        tick();

        // MUL 7*6, N=4: result 6 cycles after accept
        runTxn("mul", 32'd7, 32'd6, MUL, 5'd5, 4, 0);

        // DIVU 100/7 with five cycles of writeback backpressure
        runTxn("divu_bp", 32'd100, 32'd7, DIVU, 5'd12, 3, 5);

        // Flush two cycles after md_start while waiting
        mdLatency = 5;
        bus.wb_ready = 1'b1;
        s0 = startCount;
        a0 = ackCount;
        applyStimulus(32'd5, 32'd5, MUL, 5'd9);
        tick();
        tick();
        flush = 1'b1;
        #1;
        checkOutput("flushWait req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("flushWait draining busy", 64'(busy), 64'd1);
        cyc = 0;
        sawValid = 1'b0;
        while (!bus.md_done && cyc < 40) begin
            if (bus.wb_valid) sawValid = 1'b1;
            tick();
            cyc++;
        end
        checkOutput("flushWait ack with done", 64'(bus.md_ack), 64'd1);
        tick();
        checkOutput("flushWait idle", 64'(busy), 64'd0);
        checkOutput("flushWait no wb_valid", 64'(sawValid | bus.wb_valid), 64'd0);
        checkOutput("flushWait ack count", 64'(ackCount - a0), 64'd1);
        checkOutput("flushWait start count", 64'(startCount - s0), 64'd1);
        runTxn("rem_after_flush", 32'd100, 32'd7, REM, 5'd17, 3, 0);

        // Back-to-back: MULHU then MUL with req_valid held
        mdLatency = 2;
        bus.wb_ready = 1'b1;
        s0 = startCount;
        bus.req_op1    = 32'hFFFF_FFFF;
        bus.req_op2    = 32'd2;
        bus.req_funct3 = MULHU;
        bus.req_rd     = 5'd3;
        bus.req_valid  = 1'b1;
        #1;
        checkOutput("b2b first ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_op1    = 32'd3;
        bus.req_op2    = 32'd3;
        bus.req_funct3 = MUL;
        bus.req_rd     = 5'd4;
        waitValid(cyc);
        checkOutput("b2b first wb_data", 64'(bus.wb_data), 64'h1);
        checkOutput("b2b first wb_rd", 64'(bus.wb_rd), 64'd3);
        checkOutput("b2b overlap req_ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
        checkOutput("b2b second md_start", 64'(bus.md_start), 64'd1);
        checkOutput("b2b second no ack", 64'(bus.md_ack), 64'd0);
        checkOutput("b2b gap wb_valid", 64'(bus.wb_valid), 64'd0);
        waitValid(cyc);
        checkOutput("b2b second wb_data", 64'(bus.wb_data), 64'd9);
        checkOutput("b2b second wb_rd", 64'(bus.wb_rd), 64'd4);
        tick();
        checkOutput("b2b start count", 64'(startCount - s0), 64'd2);

        // Flush in the same cycle as md_done
        mdLatency = 3;
        a0 = ackCount;
        applyStimulus(32'd11, 32'd3, DIVU, 5'd20);
        tick();
        tick();
        tick();
        checkOutput("coinc md_done", 64'(bus.md_done), 64'd1);
        flush = 1'b1;
        #1;
        checkOutput("coinc md_ack", 64'(bus.md_ack), 64'd1);
        checkOutput("coinc req_ready during flush", 64'(bus.req_ready), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("coinc idle", 64'(busy), 64'd0);
        checkOutput("coinc req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("coinc no wb_valid", 64'(bus.wb_valid), 64'd0);
        checkOutput("coinc ack count", 64'(ackCount - a0), 64'd1);

        // Flush while the result waits for writeback
        mdLatency = 2;
        bus.wb_ready = 1'b0;
        applyStimulus(32'd8, 32'd8, MUL, 5'd1);
        waitValid(cyc);
        checkOutput("flushResp wb_valid before", 64'(bus.wb_valid), 64'd1);
        flush = 1'b1;
        #1;
        checkOutput("flushResp wb_valid dropped", 64'(bus.wb_valid), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("flushResp idle", 64'(busy), 64'd0);
        bus.wb_ready = 1'b1;

        // Randomized transactions
        for (int i = 0; i < 24; i++) begin
            runTxn($sformatf("rnd%0d", i), pickOperand(), pickOperand(),
                   3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                   $urandom_range(1, 6), $urandom_range(0, 3));
        end
        checkOutput("no err_timeout before watchdog test", 64'(errTimeout), 64'd0);

        // Watchdog: muldiv withholds md_done
        mdHold = 1'b1;
        mdLatency = 1;
        a0 = ackCount;
        applyStimulus(32'd6, 32'd7, MUL, 5'd21);
        tick();
        cyc = 0;
        while (!errTimeout && cyc < 40) begin
            tick();
            cyc++;
        end
        checkOutput("wd full wait cycles", 64'(cyc), 64'(TIMEOUT));
        repeat (3) tick();
        checkOutput("wd sticky while waiting", 64'(errTimeout), 64'd1);
        checkOutput("wd still busy", 64'(busy), 64'd1);
        mdHold = 1'b0;
        waitValid(cyc);
        checkOutput("wd late wb_valid", 64'(bus.wb_valid), 64'd1);
        checkOutput("wd late wb_data", 64'(bus.wb_data), 64'd42);
        checkOutput("wd late ack count", 64'(ackCount - a0), 64'd1);
        tick();
        checkOutput("wd sticky after completion", 64'(errTimeout), 64'd1);
        checkOutput("wd idle after completion", 64'(busy), 64'd0);

        checkOutput("start while outstanding", 64'(startOverlap), 64'd0);
        checkOutput("start with ack same cycle", 64'(startAckSame), 64'd0);

        rst_n = 1'b0;
        #1;
        checkOutput("wd cleared by reset", 64'(errTimeout), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
